// File: rtl/l2_cmd_pkg.sv
// Shared definitions for the L1->L2 bus sequencer: L2 command codes,
// default line-address width and the sequencer state encoding.
package l2_cmd_pkg;

  localparam int unsigned ADDR_W_DEF = 26;

  typedef enum logic [1:0] {
    CMD_NOP   = 2'b00,
    CMD_READ  = 2'b01,
    CMD_WRITE = 2'b10,
    CMD_RWITM = 2'b11
  } l2_cmd_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_WB   = 2'b01,
    ST_FILL = 2'b10,
    ST_DONE = 2'b11
  } seq_state_e;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter used for the L2 statistics tallies.
// Ports: clk, rst_n (async active-low), inc (count enable), cnt (value).
module sat_counter #(
  parameter int unsigned W = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         inc,
  output logic [W-1:0] cnt
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  // Hold at all-ones instead of wrapping.
  always_comb begin
    cnt_d = cnt_q;
    if (inc && (cnt_q != '1)) begin
      cnt_d = cnt_q + W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt = cnt_q;

endmodule

// File: rtl/l2_bus_sequencer.sv
// Sequences one L1 miss into an optional victim WRITE followed by a READ or
// RWITM to L2, holding each command until acknowledged or timed out.
// Ports:
//   req_*        L1 miss request handshake and payload (sampled on accept)
//   victim_*     victim line writeback need and address
//   l2_*         L2 command/address port with ack
//   resp_*       one-cycle completion pulse with timeout error flag
//   cnt_*        saturating per-command and timeout tallies
module l2_bus_sequencer
  import l2_cmd_pkg::*;
#(
  parameter int unsigned ADDR_W  = ADDR_W_DEF,
  parameter int unsigned CNT_W   = 32,
  parameter int unsigned TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic              req_write,
  input  logic              victim_dirty,
  input  logic [ADDR_W-1:0] victim_addr,
  output logic              l2_valid,
  output logic [1:0]        l2_cmd,
  output logic [ADDR_W-1:0] l2_addr,
  input  logic              l2_ack,
  output logic              resp_valid,
  output logic              resp_err,
  output logic [CNT_W-1:0]  cnt_read,
  output logic [CNT_W-1:0]  cnt_write,
  output logic [CNT_W-1:0]  cnt_rwitm,
  output logic [CNT_W-1:0]  cnt_timeout
);

  localparam int unsigned        WAIT_W    = $clog2(TIMEOUT + 1);
  localparam logic [WAIT_W-1:0]  WAIT_LAST = WAIT_W'(TIMEOUT - 1);

  seq_state_e        state_q, state_d;
  logic [ADDR_W-1:0] req_addr_q, req_addr_d;
  logic [ADDR_W-1:0] victim_addr_q, victim_addr_d;
  logic              req_write_q, req_write_d;
  logic [WAIT_W-1:0] wait_q, wait_d;

  logic              req_ready_q, req_ready_d;
  logic              l2_valid_q, l2_valid_d;
  l2_cmd_e           l2_cmd_q, l2_cmd_d;
  logic [ADDR_W-1:0] l2_addr_q, l2_addr_d;
  logic              resp_valid_q, resp_valid_d;
  logic              resp_err_q, resp_err_d;

  logic inc_read, inc_write, inc_rwitm, inc_timeout;

  // Next-state, latches, wait counter, tally strobes and next output values.
  always_comb begin
    state_d       = state_q;
    req_addr_d    = req_addr_q;
    victim_addr_d = victim_addr_q;
    req_write_d   = req_write_q;
    wait_d        = wait_q;
    inc_read      = 1'b0;
    inc_write     = 1'b0;
    inc_rwitm     = 1'b0;
    inc_timeout   = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (req_valid) begin
          req_addr_d    = req_addr;
          victim_addr_d = victim_addr;
          req_write_d   = req_write;
          wait_d        = '0;
          state_d       = victim_dirty ? ST_WB : ST_FILL;
        end
      end
      ST_WB: begin
        // Ack is checked first so an ack on the last wait cycle still counts.
        if (l2_ack) begin
          inc_write = 1'b1;
          wait_d    = '0;
          state_d   = ST_FILL;
        end else if (wait_q == WAIT_LAST) begin
          inc_timeout = 1'b1;
          wait_d      = '0;
          state_d     = ST_DONE;
        end else begin
          wait_d = wait_q + WAIT_W'(1);
        end
      end
      ST_FILL: begin
        if (l2_ack) begin
          inc_rwitm = req_write_q;
          inc_read  = !req_write_q;
          wait_d    = '0;
          state_d   = ST_DONE;
        end else if (wait_q == WAIT_LAST) begin
          inc_timeout = 1'b1;
          wait_d      = '0;
          state_d     = ST_DONE;
        end else begin
          wait_d = wait_q + WAIT_W'(1);
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Outputs are registered from the next state so they line up with it.
    req_ready_d  = (state_d == ST_IDLE);
    resp_valid_d = (state_d == ST_DONE);
    resp_err_d   = inc_timeout;
    l2_valid_d   = 1'b0;
    l2_cmd_d     = CMD_NOP;
    l2_addr_d    = '0;
    if (state_d == ST_WB) begin
      l2_valid_d = 1'b1;
      l2_cmd_d   = CMD_WRITE;
      l2_addr_d  = victim_addr_d;
    end else if (state_d == ST_FILL) begin
      l2_valid_d = 1'b1;
      l2_cmd_d   = req_write_d ? CMD_RWITM : CMD_READ;
      l2_addr_d  = req_addr_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= ST_IDLE;
      req_addr_q    <= '0;
      victim_addr_q <= '0;
      req_write_q   <= 1'b0;
      wait_q        <= '0;
      req_ready_q   <= 1'b1;
      l2_valid_q    <= 1'b0;
      l2_cmd_q      <= CMD_NOP;
      l2_addr_q     <= '0;
      resp_valid_q  <= 1'b0;
      resp_err_q    <= 1'b0;
    end else begin
      state_q       <= state_d;
      req_addr_q    <= req_addr_d;
      victim_addr_q <= victim_addr_d;
      req_write_q   <= req_write_d;
      wait_q        <= wait_d;
      req_ready_q   <= req_ready_d;
      l2_valid_q    <= l2_valid_d;
      l2_cmd_q      <= l2_cmd_d;
      l2_addr_q     <= l2_addr_d;
      resp_valid_q  <= resp_valid_d;
      resp_err_q    <= resp_err_d;
    end
  end

  assign req_ready  = req_ready_q;
  assign l2_valid   = l2_valid_q;
  assign l2_cmd     = l2_cmd_q;
  assign l2_addr    = l2_addr_q;
  assign resp_valid = resp_valid_q;
  assign resp_err   = resp_err_q;

  sat_counter #(.W(CNT_W)) u_cnt_read (
    .clk(clk), .rst_n(rst_n), .inc(inc_read), .cnt(cnt_read)
  );
  sat_counter #(.W(CNT_W)) u_cnt_write (
    .clk(clk), .rst_n(rst_n), .inc(inc_write), .cnt(cnt_write)
  );
  sat_counter #(.W(CNT_W)) u_cnt_rwitm (
    .clk(clk), .rst_n(rst_n), .inc(inc_rwitm), .cnt(cnt_rwitm)
  );
  sat_counter #(.W(CNT_W)) u_cnt_timeout (
    .clk(clk), .rst_n(rst_n), .inc(inc_timeout), .cnt(cnt_timeout)
  );

endmodule

// File: doc/l2_bus_sequencer.md
# l2_bus_sequencer

Sequencing controller between the L1 cache controller and the L2 command/address port. Each L1 miss is accepted as one request. If the L1 victim is dirty, the block first issues a WRITE (writeback) of the victim line to L2, then a READ (read miss) or RWITM (write miss) for the missing line. Each command is held until L2 acknowledges it. The block also keeps saturating per-command tallies for the simulator's statistics report.

## Interface
Parameters:
- `ADDR_W`, 26: line address width (L1↔L2 address bus).
- `CNT_W`, 32: width of each statistics counter.
- `TIMEOUT`, 255: maximum cycles to wait for `l2_ack` on one command before aborting.

Ports:
- `clk`  in  1  single clock; all logic on rising edge.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `req_valid`  in  1  L1 miss request present.
- `req_ready`  out  1  block can accept a request; high only in IDLE.
- `req_addr`  in  ADDR_W  missing line address.
- `req_write`  in  1  1 = write miss (RWITM), 0 = read miss (READ).
- `victim_dirty`  in  1  victim line is Modified and needs a writeback.
- `victim_addr`  in  ADDR_W  victim line address.
- `l2_valid`  out  1  command on `l2_cmd`/`l2_addr` is valid.
- `l2_cmd`  out  2  L2 command code.
- `l2_addr`  out  ADDR_W  L2 command address.
- `l2_ack`  in  1  L2 accepted the current command.
- `resp_valid`  out  1  one-cycle pulse: request finished.
- `resp_err`  out  1  qualifies `resp_valid`: request aborted on timeout.
- `cnt_read`, `cnt_write`, `cnt_rwitm`  out  CNT_W each  acknowledged command tallies.
- `cnt_timeout`  out  CNT_W  aborted-request tally.

## Operation
- Command codes: NOP = 2'b00, READ = 2'b01, WRITE = 2'b10, RWITM = 2'b11. All four codes are distinct.
- States: IDLE, WB, FILL, DONE.
- IDLE
  - `req_ready` = 1.
  - On `req_valid`, latch `req_addr`, `req_write`, `victim_dirty` and `victim_addr`.
  - Go to WB if `victim_dirty`, otherwise go to FILL.
- WB
  - Drive `l2_valid` = 1, `l2_cmd` = WRITE, `l2_addr` = latched victim address.
  - On `l2_ack`, go to FILL.
- FILL
  - Drive `l2_valid` = 1, `l2_cmd` = RWITM if the latched `req_write` is set, otherwise READ.
  - Drive `l2_addr` = latched request address.
  - On `l2_ack`, go to DONE.
- DONE
  - Assert `resp_valid` = 1 with `resp_err` = 0 for one cycle, then go to IDLE.
- Timeout
  - A wait counter clears on every entry to WB or FILL and increments each cycle the state is held without `l2_ack`.
  - If the counter reaches `TIMEOUT` in WB or FILL, abandon the request without issuing any remaining command.
  - Go to DONE with `resp_err` = 1 and increment `cnt_timeout`.
- Outside WB and FILL: `l2_valid` = 0, `l2_cmd` = NOP, `l2_addr` = 0.
- `l2_ack` is ignored whenever `l2_valid` = 0.
- Counters
  - Increment the matching counter in the cycle its command is acknowledged.
  - Counters saturate at all-ones and never wrap.
- Request inputs are sampled only at acceptance; later changes to them have no effect on the request in flight.

## Timing
- Reset (asynchronous assert, synchronous-release usage) drives:
  - state IDLE;
  - `req_ready` = 1;
  - `l2_valid` = 0, `l2_cmd` = NOP, `l2_addr` = 0;
  - `resp_valid` = 0, `resp_err` = 0;
  - all counters and the wait counter = 0.
- Reset mid-request drops the request with no response.
- All outputs are registered or decoded from the state register only. There is no combinational path from `req_*` or `l2_ack` to any output.
- Clean miss, accepted at cycle 0:
  - cycle 1: `l2_valid` = 1;
  - if acked in cycle 1: cycle 2 `resp_valid` = 1, cycle 3 `req_ready` = 1.
- Dirty miss: one extra cycle plus any WB ack wait. The FILL command appears the cycle after the WB ack.
- `l2_cmd` and `l2_addr` stay stable while `l2_valid` = 1 and `l2_ack` = 0.
- A request arriving during DONE is not accepted; `req_ready` = 0 until IDLE.
- Ack and timeout in the same cycle: ack wins.

## Structure
- Shared package `l2_cmd_pkg` holds:
  - the 2-bit command codes NOP, READ, WRITE, RWITM;
  - the `ADDR_W` default;
  - the state enum.
- Sub-module `sat_counter` (width-parameterised, increment enable, saturating) is instantiated four times.
- The FSM, latches and wait counter live in the top module.

## Test plan
- Clean read: `req_addr` = 26'h0001234, `req_write` = 0, `victim_dirty` = 0, ack in first cycle -> READ @ 0001234 at cycle 1, `resp_valid` at cycle 2, `cnt_read` = 1.
- Dirty write miss: victim 26'h3FFFFFF, request 26'h0000040, `req_write` = 1 -> WRITE @ 3FFFFFF, then RWITM @ 0000040 the cycle after its ack; `cnt_write` = 1, `cnt_rwitm` = 1.
- Ack stall of 10 cycles in FILL -> `l2_cmd`/`l2_addr` held constant for all 10 cycles; `req_ready` = 0 throughout; `req_*` changes during the stall ignored.
- `TIMEOUT` = 4, no ack -> `resp_valid` with `resp_err` = 1 after 4 waiting cycles; FILL never issued after a WB timeout; `cnt_timeout` = 1.
- `rst_n` low mid-FILL -> `l2_valid` drops immediately; after release, IDLE with counters 0 and no `resp_valid`.
- `CNT_W` = 2, 5 clean reads -> `cnt_read` saturates at 3.
